// File: rtl/soc_system_adc_sample_fifo.sv
// ADC sample FIFO with an Avalon-MM slave front end.
// Qualified ADC samples are queued on chip; software pops them through a
// read-to-pop DATA register and watches level, overflow and a threshold irq.
module soc_system_adc_sample_fifo #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              irq
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;
  localparam logic [1:0] AddrThresh = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic [15:0]      thresh_q, thresh_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic cs_rd, cs_wr;
  logic empty, full;
  logic flush, push_req, push, pop, overflow;
  logic [31:0] data_word;
  logic [31:0] status_word;

  // Only these writedata bits carry meaning in the register map.
  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:19], writedata[17:16]};

  // Bus qualification and FIFO event decode.
  always_comb begin
    cs_rd    = chipselect & read;
    cs_wr    = chipselect & write;
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    flush    = cs_wr & (address == AddrCtrl) & writedata[2];
    // Flush wins over any same-cycle push or pop.
    pop      = cs_rd & (address == AddrData) & ~empty & ~flush;
    push_req = en_q & in_valid;
    push     = push_req & (~full | pop) & ~flush;
    overflow = push_req & full & ~pop & ~flush;
  end

  // Next state for pointers, level and control registers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    if (cs_wr && (address == AddrStatus) && writedata[18]) ovf_d = 1'b0;
    // A new overflow in the clearing cycle is kept rather than lost.
    if (overflow) ovf_d = 1'b1;

    if (cs_wr && (address == AddrCtrl)) begin
      en_d     = writedata[0];
      irq_en_d = writedata[1];
    end
    if (cs_wr && (address == AddrThresh)) thresh_d = writedata[15:0];
  end

  // Read-data mux; readdata holds between read strobes.
  always_comb begin
    data_word = '0;
    if (!empty) begin
      data_word[DATA_W-1:0] = mem_q[rd_ptr_q];
      data_word[31]         = 1'b1;
    end
    status_word        = '0;
    status_word[15:0]  = 16'(level_q);
    status_word[16]    = empty;
    status_word[17]    = full;
    status_word[18]    = ovf_q;

    readdata_d = readdata_q;
    if (cs_rd) begin
      unique case (address)
        AddrData:   readdata_d = data_word;
        AddrStatus: readdata_d = status_word;
        AddrCtrl:   readdata_d = {30'd0, irq_en_q, en_q};
        AddrThresh: readdata_d = {16'd0, thresh_q};
        default:    readdata_d = '0;
      endcase
    end
  end

  // Interrupt computed from current registered state, one cycle behind it.
  always_comb begin
    irq_d = irq_en_q & ((32'(level_q) >= 32'(thresh_q)) | ovf_q);
  end

  // Control and status state with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= 16'd1;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // Sample storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_port;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_adc_sample_fifo.sv
// Directed bench for soc_system_adc_sample_fifo with a sample scoreboard.
module tb_soc_system_adc_sample_fifo;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] in_port;
  logic              in_valid;
  logic              irq;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of samples expected to come out of DATA, plus flag models.
  logic [DATA_W-1:0] exp_q [$];
  logic              model_en  = 1'b0;
  logic              model_ovf = 1'b0;

  soc_system_adc_sample_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .in_valid  (in_valid),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[15:0]  = 16'(exp_q.size());
    s[16]    = (exp_q.size() == 0);
    s[17]    = (exp_q.size() == DEPTH);
    s[18]    = model_ovf;
    return s;
  endfunction

  function automatic logic [31:0] exp_data_pop();
    logic [31:0] d;
    d = '0;
    if (exp_q.size() > 0) begin
      d[DATA_W-1:0] = exp_q.pop_front();
      d[31]         = 1'b1;
    end
    return d;
  endfunction

  task automatic model_push(input logic [DATA_W-1:0] v);
    if (model_en) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(v);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] v);
    @(negedge clk);
    in_valid = 1'b1; in_port = v;
    model_push(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = exp_data_pop();
    bus_read(2'd0, d);
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    bus_read(2'd1, d);
    check(tag, d, exp_status());
  endtask

  task automatic read_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] e;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; in_port = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset register values
    read_reg("rst_data", 2'd0, 32'h0);
    read_reg("rst_status", 2'd1, 32'h0001_0000);
    read_reg("rst_ctrl", 2'd2, 32'h0);
    read_reg("rst_thresh", 2'd3, 32'h1);

    // Basic push / pop
    bus_write(2'd2, 32'h1);
    model_en = 1'b1;
    push_sample(12'hABC);
    push_sample(12'h123);
    read_status("lvl2_status");
    read_data("data_abc");
    read_data("data_123");
    read_data("data_empty");

    // Overflow at DEPTH, then clear OVF
    for (int i = 0; i <= 16; i++) push_sample(DATA_W'(i));
    read_status("ovf_status");
    for (int i = 0; i < 16; i++) read_data($sformatf("drain_%0d", i));
    bus_write(2'd1, 32'h0004_0000);
    model_ovf = 1'b0;
    read_status("ovf_cleared");

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push_sample(DATA_W'(12'h100 + i));
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    in_valid = 1'b1; in_port = 12'h7FF;
    e = exp_data_pop();
    model_push(12'h7FF);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; in_valid = 1'b0;
    check("full_pushpop_data", readdata, e);
    read_status("full_pushpop_status");
    for (int i = 0; i < 16; i++) read_data($sformatf("drain2_%0d", i));
    read_data("drain2_empty");

    // Threshold interrupt
    bus_write(2'd3, 32'h4);
    bus_write(2'd2, 32'h3);
    for (int i = 0; i < 3; i++) push_sample(DATA_W'(12'h200 + i));
    @(posedge clk); #1;
    check("irq_lvl3", {31'd0, irq}, 32'h0);
    push_sample(12'h203);
    check("irq_latency", {31'd0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_lvl4", {31'd0, irq}, 32'h1);
    read_data("irq_pop");
    @(posedge clk); #1;
    check("irq_after_pop", {31'd0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) read_data($sformatf("irq_drain_%0d", i));

    // Flush with a same-cycle sample
    for (int i = 0; i < 5; i++) push_sample(DATA_W'(12'h300 + i));
    read_status("pre_flush_status");
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h5;
    in_valid = 1'b1; in_port = 12'h555;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    read_status("flush_status");
    read_reg("flush_ctrl", 2'd2, 32'h1);
    read_data("flush_data");
    push_sample(12'h321);
    read_data("post_flush_data");

    // THRESH=0 with IRQ_EN keeps irq high
    bus_write(2'd2, 32'h3);
    bus_write(2'd3, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("irq_thresh0", {31'd0, irq}, 32'h1);

    // EN=0 ignores in_valid; write to DATA is ignored
    bus_write(2'd2, 32'h2);
    model_en = 1'b0;
    push_sample(12'h111);
    bus_write(2'd0, 32'hFFFF_FFFF);
    read_status("en0_status");

    // Reset mid-operation
    bus_write(2'd2, 32'h3);
    model_en = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(DATA_W'(12'h400 + i));
    read_data("pre_reset_data");
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    model_en  = 1'b0;
    model_ovf = 1'b0;
    read_status("post_reset_status");
    read_reg("post_reset_ctrl", 2'd2, 32'h0);
    read_reg("post_reset_thresh", 2'd3, 32'h1);
    read_data("post_reset_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_adc_sample_fifo.md
# soc_system_adc_sample_fifo

Parametrised successor to the HPS-visible ADC input port: an Avalon-MM slave that captures qualified ADC samples into an on-chip FIFO instead of exposing only the live input bus. Software drains samples by reading a pop-on-read data register, and monitors fill level, overflow and a level-threshold interrupt. Sits between the ADC controller (same clock domain) and the lightweight HPS-to-FPGA bridge in soc_system.

## Interface
- DATA_W, 12: sample width; legal range 1..31.
- DEPTH, 16: FIFO depth in samples; power of two, 2..1024.
- LVL_W, derived as $clog2(DEPTH)+1 (local): level counter width.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe, qualified by chipselect.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  DATA_W  ADC sample, synchronous to clk.
- in_valid  in  1  one-cycle sample strobe from the ADC controller.
- irq  out  1  registered level interrupt.

## Operation
- Register map (word addresses):
  - 0 DATA (RO): [DATA_W-1:0] sample, [31] valid. A read pops the FIFO head; on empty it returns 0 and does not pop.
  - 1 STATUS: [15:0] level (zero-extended), [16] empty, [17] full, [18] OVF (sticky). Writing 1 to bit 18 clears OVF; other bits are RO.
  - 2 CTRL (RW): [0] EN, [1] IRQ_EN, [2] FLUSH (write-1 pulse, reads 0). Other bits read 0.
  - 3 THRESH (RW): [15:0] level threshold; upper bits read 0.
- Push: when EN=1 and in_valid=1, in_port is written at the tail, provided not full or a pop occurs in the same cycle.
- Overflow: a push while full with no simultaneous pop drops the sample and sets OVF. Existing contents are untouched.
- Simultaneous push and pop: both take effect and level is unchanged. When empty, a push and a DATA read in the same cycle return 0/valid=0; the pushed sample is stored, with no bypass.
- Flush: sets level to 0 and realigns the pointers. Any same-cycle push or pop is ignored. OVF, EN, IRQ_EN and THRESH are unchanged.
- EN=0: in_valid is ignored. The FIFO stays readable.
- Reads and writes at other addresses have no side effects. A write to address 0 is ignored.
- Level is 0..DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally. full = (level == DEPTH).
- irq is registered: irq <= IRQ_EN & ((level >= THRESH) | OVF). THRESH=0 with IRQ_EN=1 asserts irq continuously.

## Timing
- Reset values: readdata=0, irq=0, level=0, pointers=0, OVF=0, EN=0, IRQ_EN=0, THRESH=1. FIFO storage is not reset.
- Read latency is 1 cycle. readdata updates on the edge where chipselect&read is sampled, and holds its value otherwise.
- DATA read: the value is the head at the strobe edge. The level decrements on the same edge.
- Status visibility: a push or pop on edge N is visible in STATUS for a read strobed at edge N+1.
- irq follows level/OVF/CTRL/THRESH changes with 1 cycle of latency.
- Register writes take effect on the strobe edge. A FLUSH write and a simultaneous in_valid discard that sample.
- Reset mid-operation: all state above returns to reset values immediately; in-flight samples are lost.

## Test plan
- Reset, then read all four addresses -> 0, 0x00010000 (empty), 0, 1.
- EN=1, push 0xABC, 0x123 -> STATUS level=2. DATA reads return 0x80000ABC, then 0x80000123, then 0x00000000.
- DEPTH=16: push 17 samples 0..16 -> full=1, OVF=1, and 16 reads return 0..15. Write 0x40000 to STATUS -> OVF=0.
- At level=16, pulse in_valid (0x7FF) with a simultaneous DATA read -> read returns the oldest sample, level stays 16, OVF stays 0, and 0x7FF is the last sample drained.
- THRESH=4, IRQ_EN=1: push 3 samples -> irq=0. The 4th push -> irq=1 one cycle later. One read -> irq=0.
- Fill 5 samples, write CTRL=0x5 (FLUSH|EN) with in_valid high the same cycle -> level=0, empty=1, and the next read returns 0.
